inst_fetch: RTL and testbench

Instruction fetch front-end of the `jahangir` core. It owns the program counter and drives the instruction ROM port (enable, address, data). It buffers fetched words with their PCs in a small prefetch FIFO and presents them to decode over a valid/ready handshake. A redirect input supports branches and jumps: it flushes the buffer and restarts fetch at a new PC.

---
 rtl/jahangir_pkg.sv | 28 ++
 rtl/inst_fetch_if.sv | 48 ++++
 rtl/fetch_fifo.sv | 92 +++++++++
 rtl/inst_fetch.sv | 138 +++++++++++++
 tb/tb_inst_fetch.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/jahangir_pkg.sv
// ---------------------------------------------------------------------------
// jahangir_pkg
// Shared definitions for the jahangir core front-end.
//   PC_W / INST_W : program counter and instruction word widths
//   PC_STEP       : byte distance between consecutive instruction words
//   fetch_state_t : fetch FSM states (IDLE, RUN, HOLD)
//   align_pc()    : clears the byte-offset bits of a PC
// ---------------------------------------------------------------------------
package jahangir_pkg;

    localparam int PC_W   = 32;
    localparam int INST_W = 32;

    localparam logic [PC_W-1:0] PC_STEP       = 32'd4;
    localparam logic [PC_W-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    // Instructions are word aligned, so the low two address bits never matter.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// ---------------------------------------------------------------------------
// inst_fetch_if
// Bundles the ROM port, the redirect port and the decode handshake of the
// instruction fetch unit.
//   out_rom_enable / out_rom_address / in_rom_data : combinational ROM port
//   redirect_valid / redirect_pc                   : branch/jump restart
//   out_inst_valid / out_inst / out_inst_pc        : FIFO head to decode
//   in_inst_ready                                  : decode accepts the head
// Modports: master = fetch unit, slave = surrounding core / ROM / decode.
// ---------------------------------------------------------------------------
interface inst_fetch_if;
    import jahangir_pkg::*;

    logic              out_rom_enable;
    logic [PC_W-1:0]   out_rom_address;
    logic [INST_W-1:0] in_rom_data;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              out_inst_valid;
    logic [INST_W-1:0] out_inst;
    logic [PC_W-1:0]   out_inst_pc;
    logic              in_inst_ready;

    modport master (
        output out_rom_enable,
        output out_rom_address,
        input  in_rom_data,
        input  redirect_valid,
        input  redirect_pc,
        output out_inst_valid,
        output out_inst,
        output out_inst_pc,
        input  in_inst_ready
    );

    modport slave (
        input  out_rom_enable,
        input  out_rom_address,
        output in_rom_data,
        output redirect_valid,
        output redirect_pc,
        input  out_inst_valid,
        input  out_inst,
        input  out_inst_pc,
        output in_inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Synchronous prefetch FIFO with a flush input. The head is read straight out
// of the storage flops, so a word pushed into an empty FIFO becomes visible
// one cycle later (no bypass). The head reads as zero while empty.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_push        : write i_push_data (accepted when not full or popping)
//   i_pop         : advance the head (ignored when empty)
//   i_flush       : clear all entries; overrides push and pop
//   o_full        : DEPTH entries held
//   o_empty       : no entries held
//   o_count       : number of entries, clog2(DEPTH)+1 bits
//   o_head        : oldest entry
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module fetch_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic [WIDTH-1:0]         o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [CW-1:0] CNT_ONE  = 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;

    logic w_full;
    logic w_empty;
    logic w_do_pop;
    logic w_do_push;

    assign w_full    = (r_count == CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_do_pop  = i_pop && !w_empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign w_do_push = i_push && (!w_full || w_do_pop);

    // Pointer and occupancy bookkeeping; flush returns everything to reset state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CNT_ONE;
            end else if (!w_do_push && w_do_pop) begin
                r_count <= r_count - CNT_ONE;
            end
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;
    assign o_head  = w_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
// Instruction fetch front-end of the jahangir core. Owns the program counter,
// drives a combinational instruction ROM, buffers {pc, inst} pairs in a
// prefetch FIFO and hands them to decode over valid/ready. A redirect flushes
// the FIFO and restarts fetch at the new (word-aligned) PC.
//   PC_RESET   : first fetch address after reset (word aligned)
//   FIFO_DEPTH : prefetch entries (power of two, >= 2)
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   fetch_bus  : inst_fetch_if.master (ROM port, redirect, decode handshake)
// Optional feature macro: INST_FETCH_PERF_EN adds perf_fetch_cnt (pushes)
// and perf_stall_cnt (cycles blocked by a full FIFO), both saturating and
// unaffected by redirect.
// ---------------------------------------------------------------------------
module inst_fetch
    import jahangir_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_RESET   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    inst_fetch_if.master        fetch_bus
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0]         perf_fetch_cnt,
    output logic [31:0]         perf_stall_cnt
`endif
);

    localparam int ENTRY_W = PC_W + INST_W;

    fetch_state_t r_state;
    logic [PC_W-1:0] r_fetch_pc;

    logic                      w_full;
    logic                      w_empty;
    logic [$clog2(FIFO_DEPTH):0] w_count;
    logic [ENTRY_W-1:0]        w_head;
    logic                      w_pop;
    logic                      w_redirect;
    logic                      w_fetch;
    logic                      w_unused_count;

    assign w_pop      = !w_empty && fetch_bus.in_inst_ready;
    // IDLE lasts a single cycle and ignores redirects.
    assign w_redirect = fetch_bus.redirect_valid && (r_state != IDLE);
    // Fetch only in RUN, never alongside a redirect, and only if the word has a slot.
    assign w_fetch    = (r_state == RUN) && !fetch_bus.redirect_valid && (!w_full || w_pop);

    // Occupancy is tracked inside the FIFO; only full/empty steer the fetch here.
    assign w_unused_count = ^w_count;

    // Fetch FSM and program counter. Redirect wins over everything outside IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_fetch_pc <= PC_RESET;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state <= RUN;
                end
                RUN: begin
                    if (w_redirect) begin
                        r_fetch_pc <= align_pc(fetch_bus.redirect_pc);
                    end else if (w_fetch) begin
                        r_fetch_pc <= r_fetch_pc + PC_STEP;
                    end else begin
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (w_redirect) begin
                        r_fetch_pc <= align_pc(fetch_bus.redirect_pc);
                        r_state    <= RUN;
                    end else if (w_pop) begin
                        r_state <= RUN;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_fetch),
        .i_push_data ({r_fetch_pc, fetch_bus.in_rom_data}),
        .i_pop       (w_pop),
        .i_flush     (w_redirect),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign fetch_bus.out_rom_enable  = w_fetch;
    assign fetch_bus.out_rom_address = r_fetch_pc;
    assign fetch_bus.out_inst_valid  = !w_empty;
    assign fetch_bus.out_inst_pc     = w_head[ENTRY_W-1:INST_W];
    assign fetch_bus.out_inst        = w_head[INST_W-1:0];

`ifdef INST_FETCH_PERF_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_stall;
    logic        w_stall;

    // A stall is a cycle where the full FIFO, not a redirect, kept the ROM idle.
    assign w_stall = (r_state == HOLD) || ((r_state == RUN) && w_full && !w_pop);

    // Saturating event counters; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_fetch <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_fetch && (r_perf_fetch != 32'hFFFF_FFFF)) begin
                r_perf_fetch <= r_perf_fetch + 32'd1;
            end
            if (w_stall && (r_perf_stall != 32'hFFFF_FFFF)) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = r_perf_fetch;
    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// ---------------------------------------------------------------------------
// tb_inst_fetch
// Directed, table-driven bench for inst_fetch. A second instance with
// PC_RESET = 0xFFFF_FFF8 exercises PC wrap-around. The ROM model returns
// address ^ 0xA5A5_A5A5. Honours INST_FETCH_PERF_EN when defined.
// ---------------------------------------------------------------------------
module tb_inst_fetch;
    import jahangir_pkg::*;

    localparam logic [31:0] ROM_KEY = 32'hA5A5_A5A5;

    typedef struct {
        logic        redir;
        logic [31:0] redirPc;
        logic        ready;
        logic        expEn;
        logic [31:0] expAddr;
        logic        expValid;
        logic [31:0] expPc;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    vec_t phaseA[$];
    vec_t phaseB[$];

    inst_fetch_if bus();
    inst_fetch_if bus2();

`ifdef INST_FETCH_PERF_EN
    logic [31:0] perfFetch;
    logic [31:0] perfStall;
    logic [31:0] perf2Fetch;
    logic [31:0] perf2Stall;
`endif

    inst_fetch #(
        .PC_RESET   (32'h0000_0000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_bus (bus)
`ifdef INST_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perfFetch),
        .perf_stall_cnt (perfStall)
`endif
    );

    inst_fetch #(
        .PC_RESET   (32'hFFFF_FFF8),
        .FIFO_DEPTH (4)
    ) dutWrap (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch_bus (bus2)
`ifdef INST_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf2Fetch),
        .perf_stall_cnt (perf2Stall)
`endif
    );

    // Clock generation, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ROM models for both instances.
    always_comb bus.in_rom_data  = bus.out_rom_address ^ ROM_KEY;
    always_comb bus2.in_rom_data = bus2.out_rom_address ^ ROM_KEY;

    // The wrap instance always runs with decode ready and no redirects.
    initial begin
        bus2.redirect_valid = 1'b0;
        bus2.redirect_pc    = 32'h0;
        bus2.in_inst_ready  = 1'b1;
    end

    function automatic vec_t mkVec(input logic redir, input logic [31:0] redirPc, input logic ready,
                                   input logic expEn, input logic [31:0] expAddr,
                                   input logic expValid, input logic [31:0] expPc);
        vec_t v;
        v.redir    = redir;
        v.redirPc  = redirPc;
        v.ready    = ready;
        v.expEn    = expEn;
        v.expAddr  = expAddr;
        v.expValid = expValid;
        v.expPc    = expPc;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Drive one row at the falling edge, let it settle, then compare.
    task automatic applyStimulus(input vec_t v, input string tag);
        @(negedge clk);
        bus.redirect_valid = v.redir;
        bus.redirect_pc    = v.redirPc;
        bus.in_inst_ready  = v.ready;
        #1;
        checkOutput({tag, ".en"},    32'(bus.out_rom_enable),  32'(v.expEn));
        checkOutput({tag, ".addr"},  bus.out_rom_address,      v.expAddr);
        checkOutput({tag, ".valid"}, 32'(bus.out_inst_valid),  32'(v.expValid));
        if (v.expValid) begin
            checkOutput({tag, ".pc"},   bus.out_inst_pc, v.expPc);
            checkOutput({tag, ".inst"}, bus.out_inst,    v.expPc ^ ROM_KEY);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".en"},     32'(bus.out_rom_enable), 32'h0);
        checkOutput({tag, ".addr"},   bus.out_rom_address,     32'h0);
        checkOutput({tag, ".valid"},  32'(bus.out_inst_valid), 32'h0);
        checkOutput({tag, ".inst"},   bus.out_inst,            32'h0);
        checkOutput({tag, ".instPc"}, bus.out_inst_pc,         32'h0);
        checkOutput({tag, ".wrapAddr"}, bus2.out_rom_address,  32'hFFFF_FFF8);
`ifdef INST_FETCH_PERF_EN
        checkOutput({tag, ".perfFetch"}, perfFetch, 32'h0);
        checkOutput({tag, ".perfStall"}, perfStall, 32'h0);
`endif
    endtask

    initial begin
        logic [31:0] wrapPcs [3];
        checks = 0;
        errors = 0;

        // Phase A: decode always ready, straight-line fetch from reset.
        phaseA.push_back(mkVec(1'b0, 32'h0, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00));
        phaseA.push_back(mkVec(1'b0, 32'h0, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00));
        phaseA.push_back(mkVec(1'b0, 32'h0, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04));
        phaseA.push_back(mkVec(1'b0, 32'h0, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08));
        phaseA.push_back(mkVec(1'b0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1, 32'h0C));
        phaseA.push_back(mkVec(1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 1'b1, 32'h10));

        // Phase B: stall to HOLD, drain, redirect with 3 entries, redirect+pop when full.
        for (int i = 0; i < 4; i++)
            phaseB.push_back(mkVec(1'b0, 32'h0, 1'b0, 1'b1, 32'(4 * i), i != 0, 32'h0));
        for (int i = 0; i < 4; i++)
            phaseB.push_back(mkVec(1'b0, 32'h0, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0));
        phaseB.push_back(mkVec(1'b0, 32'h0,   1'b1, 1'b0, 32'h010, 1'b1, 32'h000));
        phaseB.push_back(mkVec(1'b0, 32'h0,   1'b1, 1'b1, 32'h010, 1'b1, 32'h004));
        phaseB.push_back(mkVec(1'b0, 32'h0,   1'b1, 1'b1, 32'h014, 1'b1, 32'h008));
        phaseB.push_back(mkVec(1'b0, 32'h0,   1'b1, 1'b1, 32'h018, 1'b1, 32'h00C));
        phaseB.push_back(mkVec(1'b1, 32'h103, 1'b0, 1'b0, 32'h01C, 1'b1, 32'h010));
        phaseB.push_back(mkVec(1'b0, 32'h0,   1'b1, 1'b1, 32'h100, 1'b0, 32'h000));
        phaseB.push_back(mkVec(1'b0, 32'h0,   1'b1, 1'b1, 32'h104, 1'b1, 32'h100));
        phaseB.push_back(mkVec(1'b0, 32'h0,   1'b0, 1'b1, 32'h108, 1'b1, 32'h104));
        phaseB.push_back(mkVec(1'b0, 32'h0,   1'b0, 1'b1, 32'h10C, 1'b1, 32'h104));
        phaseB.push_back(mkVec(1'b0, 32'h0,   1'b0, 1'b1, 32'h110, 1'b1, 32'h104));
        phaseB.push_back(mkVec(1'b1, 32'h200, 1'b1, 1'b0, 32'h114, 1'b1, 32'h104));
        phaseB.push_back(mkVec(1'b0, 32'h0,   1'b1, 1'b1, 32'h200, 1'b0, 32'h000));
        phaseB.push_back(mkVec(1'b0, 32'h0,   1'b1, 1'b1, 32'h204, 1'b1, 32'h200));
        phaseB.push_back(mkVec(1'b0, 32'h0,   1'b1, 1'b1, 32'h208, 1'b1, 32'h204));

        wrapPcs[0] = 32'hFFFF_FFF8;
        wrapPcs[1] = 32'hFFFF_FFFC;
        wrapPcs[2] = 32'h0000_0000;

        rst_n              = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.in_inst_ready  = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < phaseA.size(); i++) begin
            applyStimulus(phaseA[i], $sformatf("A%0d", i));
            if (i >= 1 && i <= 3) begin
                checkOutput($sformatf("wrap%0d.valid", i), 32'(bus2.out_inst_valid), 32'h1);
                checkOutput($sformatf("wrap%0d.pc", i), bus2.out_inst_pc, wrapPcs[i-1]);
            end
        end

        // Reset mid-stream, away from any clock edge: outputs must drop at once.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkResetValues("midReset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < phaseB.size(); i++) begin
            applyStimulus(phaseB[i], $sformatf("B%0d", i));
            if (i == 7) begin
                checkOutput("B7.holdState", 32'(dut.r_state), 32'(HOLD));
            end
`ifdef INST_FETCH_PERF_EN
            if (i == 19) begin
                checkOutput("B19.perfFetch", perfFetch, 32'd12);
                checkOutput("B19.perfStall", perfStall, 32'd5);
            end
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
